// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file with pending-write scoreboard.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int PEND_W_DEF = 2;
  localparam int ZERO_REG   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/sb_pend_counter.sv
// Saturating-free up/down pending-write counter for one register; clr has priority.
module sb_pend_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              is_zero,
  output logic              is_max
);
  logic [PEND_W-1:0] cnt_q;
  logic [PEND_W-1:0] cnt_d;
  logic              dec_ok;

  // A writeback with nothing pending leaves the count at zero.
  assign dec_ok = dec && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                 cnt_d = '0;
    else if (inc && !dec_ok) cnt_d = cnt_q + PEND_W'(1);
    else if (dec_ok && !inc) cnt_d = cnt_q - PEND_W'(1);
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign is_zero = (cnt_q == '0);
  assign is_max  = (cnt_q == '1);
endmodule

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with same-cycle bypass and a per-register
// pending-write scoreboard that stalls decode on RAW hazards or counter saturation.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PEND_W     = PEND_W_DEF,
  parameter int INIT_INDEX = 1,
  parameter int BYPASS     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              stall,
  output logic              pending_any,
  output logic              err_underflow
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [PEND_W-1:0] cnt   [NREG];
  logic [NREG-1:0]   is_zero;
  logic [NREG-1:0]   is_max;
  logic              err_underflow_q, err_underflow_d;
  logic              wr_live, haz1, haz2, sat, fire;

  assign wr_live = wr_en && (wr_addr != ZR);

  always_comb begin
    mem_d = mem_q;
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        mem_d[i] = (INIT_INDEX != 0) ? DATA_W'(i) : '0;
    end else if (wr_live) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd_data1 = mem_q[rd_addr1];
    if (rd_addr1 == ZR)                                  rd_data1 = '0;
    else if ((BYPASS != 0) && wr_en && wr_addr == rd_addr1) rd_data1 = wr_data;
    rd_data2 = mem_q[rd_addr2];
    if (rd_addr2 == ZR)                                  rd_data2 = '0;
    else if ((BYPASS != 0) && wr_en && wr_addr == rd_addr2) rd_data2 = wr_data;
  end

  // A source is released early when its last outstanding write lands this cycle.
  always_comb begin
    haz1 = (rd_addr1 != ZR) && !is_zero[rd_addr1] &&
           !((BYPASS != 0) && wr_en && wr_addr == rd_addr1 && cnt[rd_addr1] == PEND_W'(1));
    haz2 = (rd_addr2 != ZR) && !is_zero[rd_addr2] &&
           !((BYPASS != 0) && wr_en && wr_addr == rd_addr2 && cnt[rd_addr2] == PEND_W'(1));
    sat  = (issue_dest != ZR) && is_max[issue_dest] &&
           !(wr_en && wr_addr == issue_dest);
    stall = issue_en && (haz1 || haz2 || sat);
    fire  = issue_en && !stall;
  end

  assign cnt[0]     = '0;
  assign is_zero[0] = 1'b1;
  assign is_max[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_pend_counter #(.PEND_W(PEND_W)) u_cnt (
      .clk     (clk),
      .clr     (rst),
      .inc     (fire && issue_dest == ADDR_W'(r)),
      .dec     (wr_en && wr_addr == ADDR_W'(r)),
      .cnt     (cnt[r]),
      .is_zero (is_zero[r]),
      .is_max  (is_max[r])
    );
  end

  assign pending_any = ~&is_zero;

  always_comb begin
    err_underflow_d = err_underflow_q || (wr_live && is_zero[wr_addr]);
    if (rst) err_underflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    err_underflow_q <= err_underflow_d;
  end

  assign err_underflow = err_underflow_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, issue_dest;
  logic [31:0] rd_data1, rd_data2, wr_data;
  logic        wr_en, issue_en, stall, pending_any, err_underflow;
  int          checks = 0;
  int          errors = 0;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_dest(issue_dest),
    .stall(stall), .pending_any(pending_any), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    issue_en = 0; issue_dest = 0; rd_addr1 = 1; rd_addr2 = 2;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    rd_addr1 = 7; rd_addr2 = 31; issue_en = 1; issue_dest = 8; #1;
    checks++; if (rd_data1 !== 32'd7) begin errors++; $display("FAIL reset_rd7 got=%h exp=%h", rd_data1, 32'd7); end
    checks++; if (rd_data2 !== 32'd31) begin errors++; $display("FAIL reset_rd31 got=%h exp=%h", rd_data2, 32'd31); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", pending_any); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
    rd_addr1 = 0; #1;
    checks++; if (rd_data1 !== 32'd0) begin errors++; $display("FAIL reset_rd0 got=%h exp=0", rd_data1); end
    issue_en = 0;
  endtask

  task automatic test_write_bypass();
    do_reset();
    rd_addr1 = 4; rd_addr2 = 5; #1;
    checks++; if (rd_data1 !== 32'd4) begin errors++; $display("FAIL pre_write got=%h exp=%h", rd_data1, 32'd4); end
    wr_en = 1; wr_addr = 4; wr_data = 32'hDEADBEEF; #1;
    checks++; if (rd_data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass got=%h exp=deadbeef", rd_data1); end
    checks++; if (rd_data2 !== 32'd5) begin errors++; $display("FAIL bypass_other got=%h exp=%h", rd_data2, 32'd5); end
    tick(); wr_en = 0; #1;
    checks++; if (rd_data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_persist got=%h exp=deadbeef", rd_data1); end
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; rd_addr2 = 0; #1;
    checks++; if (rd_data2 !== 32'd0) begin errors++; $display("FAIL r0_bypass got=%h exp=0", rd_data2); end
    tick(); wr_en = 0; #1;
    checks++; if (rd_data2 !== 32'd0) begin errors++; $display("FAIL r0_write got=%h exp=0", rd_data2); end
  endtask

  task automatic test_raw_stall();
    do_reset();
    issue_en = 1; issue_dest = 5; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_first_issue stall=%b exp=0", stall); end
    tick();
    issue_dest = 0; rd_addr1 = 5;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_hold%0d stall=%b exp=1", i, stall); end
      tick();
    end
    checks++; if (pending_any !== 1'b1) begin errors++; $display("FAIL raw_pending got=%b exp=1", pending_any); end
    wr_en = 1; wr_addr = 5; wr_data = 32'h55AA; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_release stall=%b exp=0", stall); end
    checks++; if (rd_data1 !== 32'h55AA) begin errors++; $display("FAIL raw_fwd got=%h exp=55aa", rd_data1); end
    tick(); wr_en = 0; #1;
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL raw_cnt_zero pending=%b exp=0", pending_any); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_after stall=%b exp=0", stall); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL raw_no_err got=%b exp=0", err_underflow); end
    issue_en = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    issue_en = 1; issue_dest = 9;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_fill%0d stall=%b exp=0", i, stall); end
      tick();
    end
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_full stall=%b exp=1", stall); end
    wr_en = 1; wr_addr = 9; wr_data = 32'h99; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_wr_relief stall=%b exp=0", stall); end
    tick(); wr_en = 0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_still3 stall=%b exp=1", stall); end
    issue_en = 0; wr_en = 1; wr_addr = 9;
    for (int i = 0; i < 3; i++) tick();
    wr_en = 0; #1;
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL sat_drain pending=%b exp=0", pending_any); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL sat_drain_err got=%b exp=0", err_underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_init got=%b exp=0", err_underflow); end
    wr_en = 1; wr_addr = 12; wr_data = 32'h1234; #1;
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_not_yet got=%b exp=0", err_underflow); end
    tick(); wr_en = 0; rd_addr1 = 12; #1;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set got=%b exp=1", err_underflow); end
    checks++; if (rd_data1 !== 32'h1234) begin errors++; $display("FAIL uf_written got=%h exp=1234", rd_data1); end
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL uf_cnt pending=%b exp=0", pending_any); end
    tick(); tick();
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got=%b exp=1", err_underflow); end
    rst = 1; tick(); rst = 0; #1;
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got=%b exp=0", err_underflow); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    issue_en = 1; issue_dest = 3; tick(); tick();
    issue_dest = 6; tick();
    issue_en = 0; #1;
    checks++; if (pending_any !== 1'b1) begin errors++; $display("FAIL midop_pending got=%b exp=1", pending_any); end
    rst = 1; wr_en = 1; wr_addr = 3; wr_data = 32'hFFFF; issue_en = 1; issue_dest = 6;
    tick();
    rst = 0; wr_en = 0; issue_en = 0; rd_addr1 = 3; rd_addr2 = 6; #1;
    checks++; if (rd_data1 !== 32'd3) begin errors++; $display("FAIL midop_reg3 got=%h exp=%h", rd_data1, 32'd3); end
    checks++; if (rd_data2 !== 32'd6) begin errors++; $display("FAIL midop_reg6 got=%h exp=%h", rd_data2, 32'd6); end
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL midop_pending_clr got=%b exp=0", pending_any); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL midop_err got=%b exp=0", err_underflow); end
    issue_en = 1; issue_dest = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midop_stall got=%b exp=0", stall); end
    issue_en = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue_en = 1; issue_dest = 10; rd_addr1 = 1; rd_addr2 = 2; tick();
    issue_dest = 11; rd_addr2 = 10; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_src2_haz stall=%b exp=1", stall); end
    wr_en = 1; wr_addr = 10; wr_data = 32'hA0A0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_src2_rel stall=%b exp=0", stall); end
    checks++; if (rd_data2 !== 32'hA0A0) begin errors++; $display("FAIL b2b_fwd2 got=%h exp=a0a0", rd_data2); end
    tick(); wr_en = 0; issue_en = 0; rd_addr1 = 11; #1;
    checks++; if (pending_any !== 1'b1) begin errors++; $display("FAIL b2b_pending11 got=%b exp=1", pending_any); end
    issue_en = 1; issue_dest = 0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_src1_haz stall=%b exp=1", stall); end
    issue_en = 0;
  endtask

  initial begin
    idle(); rst = 1;
    test_reset();
    test_write_bypass();
    test_raw_stall();
    test_saturation();
    test_underflow();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
